shift_register_8bit: RTL and testbench

- Parallel-load, serial-shift register that forms the data path of the SPI sender and receiver.
- Sender: loads a byte in parallel, then shifts it out LSB-first on P_DATA_OUT[0].
- Receiver: shifts serial bits in at the MSB end. After WIDTH shifts, the received byte appears on P_DATA_OUT in the same bit order it was sent.
- Purely a datapath element. Bit counting, enables and tristating belong to the instantiating block.

---
 rtl/spi_pkg.sv | 15 +
 rtl/shift_register_8bit.sv | 56 +++++
 tb/tb_shift_register_8bit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//    Shared definitions for the SPI data path: the byte width, the encodings
//    of the load/shift mode select and a byte-sized type.
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_WIDTH = 8;

   localparam logic MODE_LOAD  = 1'b0;
   localparam logic MODE_SHIFT = 1'b1;

   typedef logic [SPI_WIDTH-1:0] spi_byte_t;

endpackage : spi_pkg

// File: rtl/shift_register_8bit.sv
// ---------------------------------------------------------------------------
// shift_register_8bit
//    Parallel-load / serial-shift register used as the SPI sender and
//    receiver data path. A load captures P_DATA_IN; a shift moves the word
//    one place toward bit 0, discarding bit 0 and taking S_DATA_IN into the
//    MSB. The sender reads P_DATA_OUT[0] as its serial line (LSB first); the
//    receiver, after WIDTH shifts, holds the word in its original bit order.
//
// Ports
//    CLK         in   1      rising-edge clock
//    CLR         in   1      asynchronous active-low clear to RESET_VALUE
//    P_DATA_IN   in   WIDTH  parallel load data (used only when SH_LD=0)
//    S_DATA_IN   in   1      serial data into bit WIDTH-1 (used when SH_LD=1)
//    SH_LD       in   1      0 = parallel load, 1 = shift right
//    P_DATA_OUT  out  WIDTH  register contents; bit 0 is the serial output
// ---------------------------------------------------------------------------
module shift_register_8bit
   import spi_pkg::*;
#(
   parameter int               WIDTH       = SPI_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] P_DATA_IN,
   input  logic             S_DATA_IN,
   input  logic             SH_LD,
   output logic [WIDTH-1:0] P_DATA_OUT
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   // Load/shift mux. Anything other than an explicit load selects the shift
   // path, so P_DATA_IN never reaches the register while shifting, even when
   // it floats or carries X.
   always_comb begin
      shreg_d = shreg_q;
      if (SH_LD == MODE_LOAD) begin
         shreg_d = P_DATA_IN;
      end else begin
         shreg_d = {S_DATA_IN, shreg_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         shreg_q <= RESET_VALUE;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign P_DATA_OUT = shreg_q;

endmodule : shift_register_8bit

// File: tb/tb_shift_register_8bit.sv
// ---------------------------------------------------------------------------
// tb_shift_register_8bit
//    Directed bench for shift_register_8bit. Two copies are wired as a
//    sender/receiver pair; each has its own clock so one can be exercised
//    while the other holds. When loop_en is set the receiver's serial input
//    is the sender's bit 0, otherwise the bench drives it directly.
// ---------------------------------------------------------------------------
module tb_shift_register_8bit;
   import spi_pkg::*;

   logic      tx_clk, rx_clk;
   logic      tx_clr, rx_clr;
   spi_byte_t tx_pin, rx_pin;
   logic      tx_sin, rx_sin_drv, rx_sin;
   logic      tx_shld, rx_shld;
   spi_byte_t tx_out, rx_out;
   logic      loop_en;

   int total = 0;
   int bad   = 0;

   assign rx_sin = loop_en ? tx_out[0] : rx_sin_drv;

   shift_register_8bit u_tx (
      .CLK        (tx_clk),
      .CLR        (tx_clr),
      .P_DATA_IN  (tx_pin),
      .S_DATA_IN  (tx_sin),
      .SH_LD      (tx_shld),
      .P_DATA_OUT (tx_out)
   );

   shift_register_8bit u_rx (
      .CLK        (rx_clk),
      .CLR        (rx_clr),
      .P_DATA_IN  (rx_pin),
      .S_DATA_IN  (rx_sin),
      .SH_LD      (rx_shld),
      .P_DATA_OUT (rx_out)
   );

   // One clock period on the selected copies; returns with clocks low,
   // well away from the rising edge.
   task automatic applyStimulus(input logic tx_en, input logic rx_en);
      tx_clk = tx_en;
      rx_clk = rx_en;
      #5;
      tx_clk = 1'b0;
      rx_clk = 1'b0;
      #5;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [7:0] exp_bits;
      logic [7:0] exp_after [8];
      logic [7:0] rx_bits;

      tx_clk = 1'b0;  rx_clk = 1'b0;
      tx_clr = 1'b0;  rx_clr = 1'b0;
      tx_pin = '0;    rx_pin = '0;
      tx_sin = 1'b0;  rx_sin_drv = 1'b0;
      tx_shld = MODE_LOAD; rx_shld = MODE_LOAD;
      loop_en = 1'b0;
      #3;
      checkOutput("reset_tx", tx_out, 8'h00);
      checkOutput("reset_rx", rx_out, 8'h00);
      #4;
      tx_clr = 1'b1;
      rx_clr = 1'b1;
      #3;

      // Async reset: preload 0xFF, clear between edges, hold while low
      tx_pin = 8'hFF;
      applyStimulus(1'b1, 1'b0);
      checkOutput("preload_ff", tx_out, 8'hFF);
      #2 tx_clr = 1'b0;
      #1 checkOutput("async_clear", tx_out, 8'h00);
      applyStimulus(1'b1, 1'b0);
      checkOutput("clear_held", tx_out, 8'h00);
      tx_clr = 1'b1;
      #2;

      // Parallel load, then input change with no edge; S_DATA_IN ignored
      tx_pin = 8'hA5;
      tx_sin = 1'b1;
      applyStimulus(1'b1, 1'b0);
      checkOutput("load_a5", tx_out, 8'hA5);
      tx_pin = 8'h3C;
      #3 checkOutput("load_no_edge", tx_out, 8'hA5);

      // Serial out of 0xA5, LSB first, zeros shifted in
      exp_bits  = 8'b1010_0101;  // bit i = serial bit emitted on shift i
      exp_after = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
      tx_shld = MODE_SHIFT;
      tx_sin  = 1'b0;
      tx_pin  = 'x;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("serial_bit%0d", i), {7'd0, tx_out[0]},
                     {7'd0, exp_bits[i]});
         applyStimulus(1'b1, 1'b0);
         checkOutput($sformatf("shift_val%0d", i), tx_out, exp_after[i]);
      end

      // Serial in on the receiver with P_DATA_IN floating / unknown
      rx_bits = 8'b0101_0011;    // bit i = serial bit shifted in on step i
      rx_shld = MODE_SHIFT;
      for (int i = 0; i < 8; i++) begin
         rx_pin = (i % 2 == 0) ? 8'hzz : 8'hxx;
         rx_sin_drv = rx_bits[i];
         applyStimulus(1'b0, 1'b1);
         if (i == 0) checkOutput("rx_first", rx_out, 8'h80);
      end
      checkOutput("rx_word_53", rx_out, 8'h53);

      // Mode change between edges only matters at the edge
      tx_shld = MODE_LOAD;
      tx_pin  = 8'h81;
      applyStimulus(1'b1, 1'b0);
      tx_shld = MODE_SHIFT;
      tx_pin  = 8'hFF;
      tx_sin  = 1'b0;
      #2 tx_shld = MODE_LOAD;
      #1 tx_shld = MODE_SHIFT;
      applyStimulus(1'b1, 1'b0);
      checkOutput("mode_glitch", tx_out, 8'h40);

      // Loopback: sender bit 0 feeds receiver MSB
      tx_shld = MODE_LOAD;
      tx_pin  = 8'h3C;
      applyStimulus(1'b1, 1'b0);
      checkOutput("loop_load", tx_out, 8'h3C);
      tx_shld = MODE_SHIFT;
      tx_sin  = 1'b0;
      loop_en = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("loop_rx", rx_out, 8'h3C);
      checkOutput("loop_tx_empty", tx_out, 8'h00);
      loop_en = 1'b0;

      // Reset in the middle of a shift sequence
      tx_shld = MODE_LOAD;
      tx_pin  = 8'hA5;
      applyStimulus(1'b1, 1'b0);
      tx_shld = MODE_SHIFT;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("mid_three_shifts", tx_out, 8'h14);
      #2 tx_clr = 1'b0;
      #1 checkOutput("mid_clear", tx_out, 8'h00);
      #1 tx_clr = 1'b1;
      tx_sin = 1'b1;
      #2;
      applyStimulus(1'b1, 1'b0);
      checkOutput("after_clear_shift", tx_out, 8'h80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_shift_register_8bit
